// File: rtl/dram_dump_reader_if.sv
// Memory-port and output-stream signals of the data-RAM dump reader.
// The master modport is the reader side; the slave modport is the RAM/host side.
interface dram_dump_reader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rden;
    logic [DATA_W-1:0] mem_q;
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;

    modport master (
        output mem_addr, mem_rden, dout, dout_valid,
        input  mem_q, dout_ready
    );

    modport slave (
        input  mem_addr, mem_rden, dout, dout_valid,
        output mem_q, dout_ready
    );
endinterface

// File: rtl/dram_dump_reader.sv
// Reads a block of data RAM after a program run and streams it out over valid/ready.
// Optional macro DUMP_CHECKSUM_EN appends a 16-bit modulo sum word after the data.
module dram_dump_reader #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    dram_dump_reader_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_DRAIN  = 3'd2,
        S_CSUM   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W:0]     issued_q, issued_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                inflight_q, inflight_d;
    logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    occ_q, occ_d;

    logic start_acc_s;
    logic fifo_valid_s;
    logic fifo_pop_s;
    logic credit_ok_s;
    logic issue_s;
    logic csum_valid_s;
    state_t empty_next_s;

    assign start_acc_s  = (state_q == S_IDLE) && start;
    assign fifo_valid_s = (occ_q != CNT_W'(0));
    assign fifo_pop_s   = fifo_valid_s && bus.dout_ready;

    // A word popped this cycle frees its slot, so it is not counted against the new issue.
    assign credit_ok_s = (({1'b0, occ_q} - (CNT_W+1)'(fifo_pop_s) + (CNT_W+1)'(inflight_q))
                          < (CNT_W+1)'(FIFO_DEPTH));

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    assign empty_next_s = S_CSUM;
    assign bus.dout     = csum_valid_s ? sum_q : fifo_q[rd_ptr_q];
`else
    assign empty_next_s = S_FINISH;
    assign bus.dout     = fifo_q[rd_ptr_q];
`endif

    assign bus.mem_rden   = issue_s;
    assign bus.mem_addr   = addr_q;
    assign bus.dout_valid = fifo_valid_s | csum_valid_s;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (word_count == (ADDR_W+1)'(0)) ? empty_next_s : S_READ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                state_d = (issued_q == count_q) ? S_DRAIN : S_READ;
            end
            S_DRAIN: begin
                state_d = (!fifo_valid_s && !inflight_q) ? empty_next_s : S_DRAIN;
            end
            S_CSUM: begin
                state_d = bus.dout_ready ? S_FINISH : S_CSUM;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        issue_s      = 1'b0;
        csum_valid_s = 1'b0;
        case (state_q)
            S_IDLE:   busy = 1'b0;
            S_READ: begin
                busy    = 1'b1;
                issue_s = (issued_q < count_q) && credit_ok_s;
            end
            S_DRAIN:  busy = 1'b1;
            S_CSUM: begin
                busy         = 1'b1;
                csum_valid_s = 1'b1;
            end
            S_FINISH: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default:  busy = 1'b0;
        endcase
    end

    // Datapath next values: issue counters, one-cycle read pipeline, output FIFO
    always_comb begin
        count_d    = count_q;
        issued_d   = issued_q;
        addr_d     = addr_q;
        inflight_d = issue_s;
        fifo_d     = fifo_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (start_acc_s) begin
            count_d  = word_count;
            issued_d = (ADDR_W+1)'(0);
            addr_d   = base_addr;
        end else if (issue_s) begin
            issued_d = issued_q + (ADDR_W+1)'(1);
            addr_d   = addr_q + ADDR_W'(1);
        end else begin
            issued_d = issued_q;
        end
        if (inflight_q) begin
            fifo_d[wr_ptr_q] = bus.mem_q;
            wr_ptr_d         = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (fifo_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        occ_d = occ_q + CNT_W'(inflight_q) - CNT_W'(fifo_pop_s);
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            issued_q   <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            fifo_q     <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            count_q    <= count_d;
            issued_q   <= issued_d;
            addr_q     <= addr_d;
            inflight_q <= inflight_d;
            fifo_q     <= fifo_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running sum of every captured data word
    always_comb begin
        if (start_acc_s) begin
            sum_d = DATA_W'(0);
        end else if (inflight_q) begin
            sum_d = sum_q + bus.mem_q;
        end else begin
            sum_d = sum_q;
        end
    end

    // Checksum register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

endmodule

// File: tb/tb_dram_dump_reader.sv
// Randomized bench for dram_dump_reader: a RAM model feeds the reader and a
// queue of expected words, built directly from memory contents, checks the stream.
module tb_dram_dump_reader;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W:0]   word_count = '0;
    logic              busy;
    logic              done;

    dram_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dram_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .bus        (bus.master)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [512];

    // Synchronous-read RAM: q valid the cycle after rden is sampled
    always @(posedge clk) begin
        if (bus.mem_rden) bus.mem_q <= mem[bus.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    logic [DATA_W-1:0] expq [$];
    int  k, first_k, last_k, done_k, done_cnt, issued, accepted, cur_base;
    bit  done_seen, prev_stall;
    logic [DATA_W-1:0] prev_dout;
    bit  pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Observe one cycle at the falling edge
    task automatic monitor_step();
        if (bus.mem_rden) begin
            check_eq("rden_busy", 32'(busy), 32'd1);
            check_eq("rd_addr", 32'(bus.mem_addr), 32'((cur_base + issued) % 512));
            issued++;
        end
        if (prev_stall) check_eq("stall_stable", 32'({bus.dout_valid, bus.dout}), 32'({1'b1, prev_dout}));
        if (bus.dout_valid && bus.dout_ready) begin
            if (first_k < 0) first_k = k;
            last_k = k;
            if (expq.size() == 0) check_eq("extra_word", 32'd1, 32'd0);
            else check_eq("dout", 32'(bus.dout), 32'(expq.pop_front()));
            accepted++;
        end
        if (bus.mem_rden) check_eq("credit", 32'((issued - accepted) <= DEPTH), 32'd1);
        if (k == 0) check_eq("busy_rise", 32'(busy), 32'd1);
        if (done) begin
            done_cnt++;
            done_k = k;
            done_seen = 1'b1;
        end
        prev_stall = bus.dout_valid && !bus.dout_ready;
        prev_dout  = bus.dout;
        k++;
    endtask

    function automatic logic ready_for(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        if (mode == 2) return pat[cyc % 6];
        return 1'($urandom_range(0, 1));
    endfunction

    // One complete dump: mode 0 = always ready, 1 = random, 2 = fixed toggle pattern
    task automatic run_dump(input int base, input int cnt, input int mode, input bit restart);
        logic [DATA_W-1:0] sum = '0;
        int budget = cnt * 20 + 100;
        expq.delete();
        for (int i = 0; i < cnt; i++) begin
            expq.push_back(mem[(base + i) % 512]);
            sum = sum + mem[(base + i) % 512];
        end
`ifdef DUMP_CHECKSUM_EN
        expq.push_back(sum);
`endif
        issued = 0; accepted = 0; first_k = -1; last_k = -1; done_k = -1;
        done_cnt = 0; done_seen = 1'b0; prev_stall = 1'b0; cur_base = base;
        @(posedge clk); #1;
        start = 1'b1; base_addr = ADDR_W'(base); word_count = (ADDR_W+1)'(cnt);
        @(posedge clk); #1;
        start = 1'b0; base_addr = ADDR_W'($urandom); word_count = (ADDR_W+1)'($urandom);
        k = 0;
        bus.dout_ready = ready_for(mode, 0);
        while (!done_seen && k < budget) begin
            @(negedge clk);
            monitor_step();
            if (done_seen) break;
            @(posedge clk); #1;
            start = restart && (k == 3);
            base_addr = ADDR_W'($urandom); word_count = (ADDR_W+1)'($urandom_range(1, 512));
            bus.dout_ready = ready_for(mode, k);
        end
        check_eq("done_seen", 32'(done_seen), 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        check_eq("busy_fall", 32'(busy), 32'd0);
        check_eq("done_once", 32'(done_cnt + int'(done)), 32'd1);
        check_eq("leftover", 32'(expq.size()), 32'd0);
        check_eq("rd_count", 32'(issued), 32'(cnt));
`ifndef DUMP_CHECKSUM_EN
        if (mode == 0 && cnt > 0) begin
            check_eq("first_lat", 32'(first_k), 32'd2);
            check_eq("streak", 32'(last_k - first_k + 1), 32'(cnt));
        end
        if (cnt == 0) check_eq("zero_done", 32'(done_k <= 2), 32'd1);
`endif
    endtask

    initial begin
        bus.dout_ready = 1'b1;
        for (int i = 0; i < 512; i++) mem[i] = 16'h1000 + 16'(i);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rden", 32'(bus.mem_rden), 32'd0);
        check_eq("rst_addr", 32'(bus.mem_addr), 32'd0);
        check_eq("rst_dout", 32'(bus.dout), 32'd0);
        check_eq("rst_valid", 32'(bus.dout_valid), 32'd0);
        rst_n = 1'b1;

        run_dump(9'h010, 4, 0, 1'b0);
        run_dump(9'h1FE, 4, 0, 1'b0);
        run_dump(9'h020, 6, 2, 1'b0);
        run_dump(0, 0, 0, 1'b0);
        run_dump(9'h050, 10, 1, 1'b1);

        // Reset in the middle of a stalled dump
        @(posedge clk); #1;
        start = 1'b1; base_addr = 9'h100; word_count = 10'd20; bus.dout_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(busy), 32'd1);
        check_eq("mid_valid", 32'(bus.dout_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_valid", 32'(bus.dout_valid), 32'd0);
        check_eq("abort_rden", 32'(bus.mem_rden), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_dump(9'h030, 5, 0, 1'b0);

        mem[9'h040] = 16'hFFFF;
        mem[9'h041] = 16'h0002;
        run_dump(9'h040, 2, 0, 1'b0);

        for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
        for (int t = 0; t < 8; t++) begin
            run_dump($urandom_range(0, 511), $urandom_range(0, 40), $urandom_range(0, 2), 1'b0);
        end
        run_dump($urandom_range(0, 511), 512, 0, 1'b0);
        run_dump($urandom_range(0, 511), 512, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
